// File: rtl/dm_arb_pkg.sv
// ============================================================================
// Module : dm_arb_pkg
// Brief  : Shared sizes, state encoding and requester IDs for dm_arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dm_arb_pkg;

    localparam int DM_DEPTH = 3072;
    localparam int DM_AW    = 12;
    localparam int DM_DW    = 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    // Debug-port writes carry no instruction PC, so traces show this marker
    localparam logic [31:0] DBG_TRACE_PC = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; on a tie the requester not granted last wins
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == REQ_CPU) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// ============================================================================
// Module : dm_arbiter
// Brief  : Round-robin cpu/dbg access to single-port data memory with zero-fill
//          sweep and registered read data. Optional write trace: DM_ARB_TRACE_EN
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH,
    parameter int AW    = DM_AW,
    parameter int DW    = DM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic [31:0]   cpu_pc,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [DW-1:0] dbg_rdata,
    output logic          err,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    req_id_e       last_q, last_d;
    logic          cpu_rvalid_q, dbg_rvalid_q, err_q;
    logic [DW-1:0] cpu_rdata_q, dbg_rdata_q;

    logic          w_arb_en;
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;
    logic          w_any_gnt;
    logic          w_sel_dbg;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [DW-1:0] w_wdata;
    logic [AW-1:0] w_word;
    logic          w_in_range;
    logic          w_unused;

    // A clear request in RUN masks both requesters so nothing is granted that cycle
    assign w_arb_en = (state_q == ST_RUN) && !clr_req;
    assign w_req    = {dbg_req, cpu_req} & {2{w_arb_en}};

    rr_arb2 u_rr_arb2 (
        .req  (w_req),
        .last (last_q),
        .gnt  (w_gnt)
    );

    assign w_any_gnt  = |w_gnt;
    assign w_sel_dbg  = w_gnt[1];
    assign w_we       = w_sel_dbg ? dbg_we    : cpu_we;
    assign w_addr     = w_sel_dbg ? dbg_addr  : cpu_addr;
    assign w_wdata    = w_sel_dbg ? dbg_wdata : cpu_wdata;
    assign w_word     = w_addr[AW+1:2];
    assign w_in_range = ({1'b0, w_word} < DEPTH_W) && (w_addr[31:AW+2] == '0);

    assign cpu_gnt    = w_gnt[0];
    assign dbg_gnt    = w_gnt[1];
    assign cpu_rvalid = cpu_rvalid_q;
    assign dbg_rvalid = dbg_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign err        = err_q;

    // PC is only consumed by the optional trace; byte-offset bits are ignored
    assign w_unused = ^{cpu_pc, w_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        last_d    = last_q;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_ptr_q;
                clr_ptr_d = clr_ptr_q + AW'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d   = ST_RUN;
                    clr_ptr_d = '0;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_ptr_d = '0;
                end else if (w_any_gnt) begin
                    mem_we    = w_we & w_in_range;
                    mem_addr  = w_word;
                    mem_wdata = w_wdata;
                    last_d    = w_sel_dbg ? REQ_DBG : REQ_CPU;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
            last_q       <= REQ_DBG;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
            last_q       <= last_d;
            cpu_rvalid_q <= w_gnt[0] & ~cpu_we;
            dbg_rvalid_q <= w_gnt[1] & ~dbg_we;
            err_q        <= w_any_gnt & ~w_in_range;
            if (w_gnt[0] && !cpu_we) begin
                cpu_rdata_q <= w_in_range ? mem_rdata : '0;
            end
            if (w_gnt[1] && !dbg_we) begin
                dbg_rdata_q <= w_in_range ? mem_rdata : '0;
            end
        end
    end

`ifdef DM_ARB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && w_any_gnt && w_we && w_in_range) begin
            $display("%d@%h: *%h <= %h", $time,
                     w_sel_dbg ? DBG_TRACE_PC : cpu_pc,
                     {w_addr[31:2], 2'b00}, w_wdata);
        end
    end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// ============================================================================
// Module : tb_dm_arbiter
// Brief  : Self-checking bench for dm_arbiter: directed vectors, clear/reset
//          sequences and randomized traffic against a behavioural model
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dm_arbiter;

    localparam int DEPTH = 3072;

    logic        clk;
    logic        reset;
    logic        clr_req;
    logic        busy;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        err;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int errors;
    int checks;

    dm_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .busy       (busy),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_pc     (cpu_pc),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_gnt    (dbg_gnt),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .err        (err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Environment memory: combinational read, synchronous write
    logic [31:0] mem [0:4095];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Counts busy cycles from the next falling edge; returns at the first idle one
    task automatic sweep(output int cyc, output int bad);
        cyc = 0;
        bad = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy) break;
            if (mem_we !== 1'b1 || mem_addr !== 12'(cyc) || mem_wdata !== 32'h0 ||
                cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) bad++;
            cyc++;
        end
    endtask

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic [1:0]  gnt;
        logic        mwe;
        logic [11:0] maddr;
        logic        crv;
        logic [31:0] crd;
        logic        drv;
        logic [31:0] drd;
        logic        err;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    function automatic logic [31:0] rnd_addr();
        logic [31:0] w;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: w = $urandom_range(0, 15);
            6:       w = 32'd3071;
            7:       w = 32'd3072;
            8:       w = $urandom_range(3073, 4095);
            default: w = $urandom_range(0, 15) | (32'h1 << $urandom_range(12, 29));
        endcase
        return (w << 2) | $urandom_range(0, 3);
    endfunction

    logic [31:0] ref_mem [0:DEPTH-1];
    int          ref_last;
    int          cyc, bad, win;
    logic [31:0] a, wd;
    logic        we, inr;
    logic [1:0]  exp_gnt;

    initial begin
        errors = 0;
        checks = 0;
        reset = 1'b1;  clr_req = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_pc = 32'h0000_1000;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

        vec[0]  = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0,
                    2'b01, 1'b1, 12'h004, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    2'b01, 1'b0, 12'h004, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                    2'b10, 1'b1, 12'h008, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                    2'b01, 1'b0, 12'h004, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        vec[4]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                    2'b10, 1'b0, 12'h008, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0};
        vec[5]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                    2'b01, 1'b0, 12'h004, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0};
        vec[6]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                    2'b10, 1'b0, 12'h008, 1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h3000, 32'hAAAA5555,
                    2'b10, 1'b0, 12'hC00, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'h0,
                    2'b10, 1'b0, 12'hC00, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1};
        vec[9]  = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    2'b00, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[10] = '{1'b1, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    2'b01, 1'b0, 12'h004, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1};
        vec[11] = '{1'b1, 1'b1, 32'h2FFF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 32'h0,
                    2'b01, 1'b1, 12'hBFF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[12] = '{1'b1, 1'b0, 32'h2FFC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    2'b01, 1'b0, 12'hBFF, 1'b1, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0};
        vec[13] = '{1'b1, 1'b1, 32'h40, 32'h1, 1'b1, 1'b1, 32'h44, 32'h2,
                    2'b10, 1'b1, 12'h011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vec[14] = '{1'b1, 1'b0, 32'h44, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0,
                    2'b01, 1'b0, 12'h011, 1'b1, 32'h2, 1'b0, 32'h0, 1'b0};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_busy", busy, 1);
        chk("reset_cpu_rvalid", cpu_rvalid, 0);
        chk("reset_dbg_rvalid", dbg_rvalid, 0);
        chk("reset_err", err, 0);
        chk("reset_cpu_rdata", cpu_rdata, 0);
        chk("reset_dbg_rdata", dbg_rdata, 0);

        // Requests held through the sweep must be neither granted nor lost
        cpu_req = 1'b1;
        dbg_req = 1'b1;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || mem_addr !== 12'(k) || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) bad++;
        end
        chk("partial_sweep", bad, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sweep(cyc, bad);
        chk("sweep_cycles", cyc, DEPTH);
        chk("sweep_bad_cycles", bad, 0);
        chk("first_run_gnt", {dbg_gnt, cpu_gnt}, 2'b01);
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk);
        #1;
        chk("dropped_req_no_rvalid", cpu_rvalid, 0);

        for (int i = 0; i < NV; i++) begin
            cpu_req = vec[i].cr; cpu_we = vec[i].cw; cpu_addr = vec[i].ca; cpu_wdata = vec[i].cd;
            dbg_req = vec[i].dr; dbg_we = vec[i].dw; dbg_addr = vec[i].da; dbg_wdata = vec[i].dd;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), {dbg_gnt, cpu_gnt}, vec[i].gnt);
            chk($sformatf("vec%0d_mem_we", i), mem_we, vec[i].mwe);
            chk($sformatf("vec%0d_mem_addr", i), mem_addr, vec[i].maddr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cpu_rvalid", i), cpu_rvalid, vec[i].crv);
            chk($sformatf("vec%0d_dbg_rvalid", i), dbg_rvalid, vec[i].drv);
            chk($sformatf("vec%0d_err", i), err, vec[i].err);
            if (vec[i].crv) chk($sformatf("vec%0d_cpu_rdata", i), cpu_rdata, vec[i].crd);
            if (vec[i].drv) chk($sformatf("vec%0d_dbg_rdata", i), dbg_rdata, vec[i].drd);
        end
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;

        // Clear request beats a same-cycle cpu read; the read completes after the sweep
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10; clr_req = 1'b1;
        @(negedge clk);
        chk("clr_cycle_no_gnt", {dbg_gnt, cpu_gnt}, 2'b00);
        @(posedge clk);
        #1 clr_req = 1'b0;
        chk("clr_busy_next", busy, 1);
        chk("clr_no_rvalid", cpu_rvalid, 0);
        sweep(cyc, bad);
        chk("clr_sweep_cycles", cyc, DEPTH);
        chk("clr_sweep_bad_cycles", bad, 0);
        chk("clr_first_run_gnt", {dbg_gnt, cpu_gnt}, 2'b01);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        chk("clr_read_rvalid", cpu_rvalid, 1);
        chk("clr_read_zeroed", cpu_rdata, 0);

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_last = 0;
        for (int n = 0; n < 400; n++) begin
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = $urandom_range(0, 1) == 1;
            cpu_addr  = rnd_addr();
            cpu_wdata = $urandom;
            dbg_req   = ($urandom_range(0, 9) < 6);
            dbg_we    = $urandom_range(0, 1) == 1;
            dbg_addr  = rnd_addr();
            dbg_wdata = $urandom;
            if (cpu_req && dbg_req) win = (ref_last == 0) ? 1 : 0;
            else if (cpu_req)       win = 0;
            else if (dbg_req)       win = 1;
            else                    win = -1;
            exp_gnt = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
            a   = (win == 1) ? dbg_addr  : cpu_addr;
            we  = (win == 1) ? dbg_we    : cpu_we;
            wd  = (win == 1) ? dbg_wdata : cpu_wdata;
            inr = a < 32'(DEPTH * 4);
            @(negedge clk);
            chk("rnd_gnt", {dbg_gnt, cpu_gnt}, exp_gnt);
            chk("rnd_mem_we", mem_we, (win >= 0) && we && inr);
            chk("rnd_mem_addr", mem_addr, (win >= 0) ? 12'((a >> 2) & 32'hFFF) : 12'h0);
            @(posedge clk);
            #1;
            chk("rnd_cpu_rvalid", cpu_rvalid, (win == 0) && !we);
            chk("rnd_dbg_rvalid", dbg_rvalid, (win == 1) && !we);
            chk("rnd_err", err, (win >= 0) && !inr);
            if (win == 0 && !we) chk("rnd_cpu_rdata", cpu_rdata, inr ? ref_mem[int'(a >> 2)] : 32'h0);
            if (win == 1 && !we) chk("rnd_dbg_rdata", dbg_rdata, inr ? ref_mem[int'(a >> 2)] : 32'h0);
            if (win >= 0 && we && inr) ref_mem[int'(a >> 2)] = wd;
            if (win >= 0) ref_last = win;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Sits between two requesters and the single-port data memory (3072 words, word-addressed by byte address bits [13:2]): the pipeline MEM stage (cpu) and a debug/DMA loader (dbg).
- Grants one word access per cycle using round-robin arbitration.
- Registers read data and sequences a multi-cycle zero-fill of the whole memory after reset, or on request.
- Replaces the single-cycle reset loop inside the memory.

Parameters:
- DEPTH, 3072, memory size in words
- AW, 12, word-address width (ceil log2 DEPTH)
- DW, 32, data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clr_req  in  1  pulse: start a zero-fill sweep
- busy  out  1  high while a zero-fill sweep is running
- cpu_req  in  1  cpu access request, held until granted
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wdata  in  32  write data
- cpu_pc  in  32  PC of the requesting instruction (trace only)
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  read data valid (one cycle after a read grant)
- cpu_rdata  out  32  registered read data
- dbg_req, dbg_we, dbg_addr[31:0], dbg_wdata[31:0]  in  same meaning as the cpu_* inputs
- dbg_gnt, dbg_rvalid, dbg_rdata[31:0]  out  same meaning as the cpu_* outputs
- err  out  1  one-cycle pulse: a granted access had an out-of-range address
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data

Behaviour:
- Reset (clk edge with reset=1):
  - state<=CLEAR, clr_ptr<=0, last<=dbg (so cpu wins the first tie).
  - All *_gnt, *_rvalid and err are 0; *_rdata<=0.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle: mem_we=1, mem_addr=clr_ptr, mem_wdata=0; clr_ptr increments.
  - At clr_ptr==DEPTH-1, go to RUN next cycle.
  - Sweep lasts exactly DEPTH cycles; busy=1 throughout.
  - No grants; requests are held off, not dropped.
- RUN:
  - busy=0.
  - clr_req=1 → CLEAR next cycle, clr_ptr<=0. clr_req takes precedence over any same-cycle request: no grant that cycle.
- Arbitration in RUN:
  - One requester active → it is granted.
  - Both active → grant the one not equal to last.
  - last updates on every grant.
  - gnt is combinational and asserted in the same cycle as the accepted req.
- Memory drive:
  - mem_addr = granted addr[AW+1:2].
  - mem_we = granted we AND in-range; mem_wdata = granted wdata.
  - With no grant and not in CLEAR: mem_we=0, mem_addr=0.
- Read latency: on a read grant, the granted requester's rdata<=mem_rdata and rvalid<=1 at the next edge; rvalid is a one-cycle pulse.
- Range check: out of range when word address ≥ DEPTH or addr[31:AW+2]≠0.
  - Write: suppressed.
  - Read: returns 0 with rvalid=1.
  - err pulses 1 the cycle after the grant in both cases.
- Reset during CLEAR restarts the sweep from 0.
- Back-to-back grants to the same requester are allowed when the other is idle.

Optional Feature:
- Macro: DM_ARB_TRACE_EN.
- Defined: on each granted in-range write, print with $display, format "%d@%h: *%h <= %h".
  - Fields: $time, cpu_pc (dbg writes use 32'hFFFF_FFFF), byte address with [1:0] forced to 0, data.
  - Zero-fill writes are not printed.
- Undefined: no display statements, identical RTL otherwise.

Decomposition:
- Package dm_arb_pkg:
  - DEPTH/AW defaults.
  - State encoding (ST_CLEAR, ST_RUN).
  - Requester IDs (REQ_CPU=0, REQ_DBG=1).
  - DBG_TRACE_PC constant.
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], last, gnt[1:0]).

Test Plan:
- Reset, then count cycles → busy=1 for exactly 3072 cycles with mem_we=1 and mem_addr 0..3071; no gnt asserted.
- After clear: cpu write 0x0000_0010 ← 0xDEADBEEF, then cpu read 0x10 → cpu_gnt both cycles; cpu_rvalid=1 one cycle after the read grant; cpu_rdata=0xDEADBEEF.
- cpu_req and dbg_req held 4 cycles → grants alternate cpu, dbg, cpu, dbg.
- dbg write to 0x0000_3000 (word 3072) → mem_we=0, err pulses once; a subsequent read of 0x3000 → dbg_rdata=0, dbg_rvalid=1, err=1.
- clr_req in the same cycle as cpu_req → no cpu_gnt; busy=1 next cycle; cpu granted the first RUN cycle after 3072 cycles; previously written word reads 0.
- Reset asserted at sweep cycle 100 → clr_ptr restarts at 0 and the full 3072-cycle sweep follows.
